// File: rtl/fp_pkg.sv
// Shared constants and the write-back request type for the FP write-back path.
package fp_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned FLAGW   = 5;
    localparam int unsigned FREG_AW = 5;

    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    typedef struct packed {
        logic [FREG_AW-1:0] frd;
        logic [XLEN-1:0]    data;
        logic [FLAGW-1:0]   flags;
    } fp_wb_req_t;

endpackage

// File: rtl/fp_wb_slot.sv
// One-entry result buffer; ready depends only on the stored state and the pop.
module fp_wb_slot
    import fp_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [FREG_AW-1:0] frd_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [FLAGW-1:0]   flags_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic [FREG_AW-1:0] frd_o,
    output logic [XLEN-1:0]    data_o,
    output logic [FLAGW-1:0]   flags_o
);

    logic       full_q, full_d;
    logic       accept;
    fp_wb_req_t req_q, req_d;

    always_comb begin
        ready_o = ~full_q | pop_i;
        accept  = valid_i & ready_o;
        full_d  = accept | (full_q & ~pop_i);
        req_d   = req_q;
        if (accept) begin
            req_d = '{frd: frd_i, data: data_i, flags: flags_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign full_o  = full_q;
    assign frd_o   = req_q.frd;
    assign data_o  = req_q.data;
    assign flags_o = req_q.flags;

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP write-back arbiter: merges fast/slow results into the register-file port,
// keeps the pending-write scoreboard and the sticky exception flags.
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NREG       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    input  logic [FREG_AW-1:0] issue_frd_i,
    input  logic [14:0]        issue_rs_i,
    output logic               issue_stall_o,
    input  logic               fast_valid_i,
    output logic               fast_ready_o,
    input  logic [FREG_AW-1:0] fast_frd_i,
    input  logic [XLEN-1:0]    fast_data_i,
    input  logic [FLAGW-1:0]   fast_flags_i,
    input  logic               slow_valid_i,
    output logic               slow_ready_o,
    input  logic [FREG_AW-1:0] slow_frd_i,
    input  logic [XLEN-1:0]    slow_data_i,
    input  logic [FLAGW-1:0]   slow_flags_i,
    output logic               fregwrite_o,
    output logic [FREG_AW-1:0] frd_o,
    output logic [XLEN-1:0]    writeback_data_o,
    output logic [NREG-1:0]    pending_o,
    input  logic               fflags_clr_i,
    output logic [FLAGW-1:0]   fflags_o
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

    logic               fast_full, slow_full;
    logic [FREG_AW-1:0] fast_frd, slow_frd;
    logic [XLEN-1:0]    fast_data, slow_data;
    logic [FLAGW-1:0]   fast_flags, slow_flags;
    fp_wb_req_t         fast_req, slow_req, win_req;

    logic               grant_fast, grant_slow, grant;
    logic               starve_sat;
    logic               issue_take;

    logic [StarveW-1:0] starve_q, starve_d;
    logic [NREG-1:0]    pending_q, pending_d;
    logic [FLAGW-1:0]   fflags_q, fflags_d;
    logic               fregwrite_q;
    logic [FREG_AW-1:0] frd_q;
    logic [XLEN-1:0]    wb_data_q;

    fp_wb_slot u_fast_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (fast_valid_i),
        .ready_o (fast_ready_o),
        .frd_i   (fast_frd_i),
        .data_i  (fast_data_i),
        .flags_i (fast_flags_i),
        .pop_i   (grant_fast),
        .full_o  (fast_full),
        .frd_o   (fast_frd),
        .data_o  (fast_data),
        .flags_o (fast_flags)
    );

    fp_wb_slot u_slow_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slow_valid_i),
        .ready_o (slow_ready_o),
        .frd_i   (slow_frd_i),
        .data_i  (slow_data_i),
        .flags_i (slow_flags_i),
        .pop_i   (grant_slow),
        .full_o  (slow_full),
        .frd_o   (slow_frd),
        .data_o  (slow_data),
        .flags_o (slow_flags)
    );

    assign fast_req = '{frd: fast_frd, data: fast_data, flags: fast_flags};
    assign slow_req = '{frd: slow_frd, data: slow_data, flags: slow_flags};

    // Arbitration looks only at slot occupancy, never at the valid inputs.
    always_comb begin
        starve_sat = (starve_q >= StarveW'(STARVE_MAX));
        grant_fast = fast_full & (~slow_full | ~starve_sat);
        grant_slow = slow_full & ~grant_fast;
        grant      = grant_fast | grant_slow;
        win_req    = grant_slow ? slow_req : fast_req;
    end

    always_comb begin
        starve_d = starve_q;
        if (~slow_full | grant_slow) begin
            starve_d = '0;
        end else if (grant_fast & ~starve_sat) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        issue_stall_o = issue_valid_i & (pending_q[issue_frd_i]       |
                                         pending_q[issue_rs_i[4:0]]   |
                                         pending_q[issue_rs_i[9:5]]   |
                                         pending_q[issue_rs_i[14:10]]);
        issue_take    = issue_valid_i & ~issue_stall_o;
    end

    // Clear first, then set, so a same-register issue wins over the retiring write.
    always_comb begin
        pending_d = pending_q;
        if (grant) begin
            pending_d[win_req.frd] = 1'b0;
        end
        if (issue_take) begin
            pending_d[issue_frd_i] = 1'b1;
        end
    end

    always_comb begin
        fflags_d = (fflags_clr_i ? '0 : fflags_q) | (grant ? win_req.flags : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q    <= '0;
            pending_q   <= '0;
            fflags_q    <= '0;
            fregwrite_q <= 1'b0;
            frd_q       <= '0;
            wb_data_q   <= '0;
        end else begin
            starve_q    <= starve_d;
            pending_q   <= pending_d;
            fflags_q    <= fflags_d;
            fregwrite_q <= grant;
            if (grant) begin
                frd_q     <= win_req.frd;
                wb_data_q <= win_req.data;
            end
        end
    end

    assign fregwrite_o      = fregwrite_q;
    assign frd_o            = frd_q;
    assign writeback_data_o = wb_data_q;
    assign pending_o        = pending_q;
    assign fflags_o         = fflags_q;

endmodule
